// File: rtl/tap_bank_if.sv
// tap_bank_if: write, clear, readback and status bundle for tap_bank.
`default_nettype none

interface tap_bank_if #(
  parameter int NTAPS = 16,
  parameter int TW    = 16
);
  logic                  i_tap_wr;
  logic [TW-1:0]         i_tap;
  logic                  i_clear;
  logic                  i_rd_start;
  logic                  i_rd_ready;
  logic                  o_rd_valid;
  logic [TW-1:0]         o_rd_data;
  logic [3:0]            o_rd_idx;
  logic                  o_rd_done;
  logic [4:0]            o_count;
  logic                  o_loaded;
  logic                  o_err;
  logic [NTAPS*TW-1:0]   o_taps;
  logic [19:0]           o_checksum;

  modport master (
    output i_tap_wr, i_tap, i_clear, i_rd_start, i_rd_ready,
    input  o_rd_valid, o_rd_data, o_rd_idx, o_rd_done, o_count,
           o_loaded, o_err, o_taps, o_checksum
  );

  modport slave (
    input  i_tap_wr, i_tap, i_clear, i_rd_start, i_rd_ready,
    output o_rd_valid, o_rd_data, o_rd_idx, o_rd_done, o_count,
           o_loaded, o_err, o_taps, o_checksum
  );
endinterface

`default_nettype wire

// File: rtl/tap_bank.sv
// tap_bank: shift-in coefficient bank with write-order serial readback.
// Optional running checksum enabled by defining TAP_BANK_CHECKSUM_EN.
`default_nettype none

module tap_bank #(
  parameter int NTAPS = 16,
  parameter int TW    = 16
) (
  input  logic        clk,
  input  logic        i_reset,
  tap_bank_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] C_FULL     = 5'(NTAPS);
  localparam logic [3:0] C_LAST_IDX = 4'(NTAPS - 1);

  state_t        r_state;
  state_t        w_state_nx;
  logic [TW-1:0] r_taps [NTAPS];
  logic [4:0]    r_count;
  logic          r_err;
  logic [3:0]    r_rd_idx;
  logic [3:0]    w_rd_sel;
  logic          w_loaded;
  logic          w_accept;
  logic          w_transfer;
  logic          w_start;

  assign w_loaded   = (r_count == C_FULL);
  assign w_accept   = bus.i_tap_wr & ~bus.i_clear & (r_state != S_READ);
  assign w_transfer = (r_state == S_READ) & bus.i_rd_ready;
  assign w_start    = (r_state == S_IDLE) & bus.i_rd_start & w_loaded & ~bus.i_clear;
  // Oldest write sits at the top of the bank, so invert the index for write order.
  assign w_rd_sel   = C_LAST_IDX - r_rd_idx;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nx = S_READ;
      S_READ: begin
        if (bus.i_clear) begin
          w_state_nx = S_IDLE;
        end else if (w_transfer && (r_rd_idx == C_LAST_IDX)) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_taps[k] <= '0;
      end
    end else if (w_accept) begin
      for (int k = NTAPS - 1; k > 0; k--) begin
        r_taps[k] <= r_taps[k-1];
      end
      r_taps[0] <= bus.i_tap;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_count  <= '0;
      r_err    <= 1'b0;
      r_rd_idx <= '0;
    end else begin
      if (bus.i_clear) begin
        r_count <= '0;
        r_err   <= 1'b0;
      end else begin
        if (w_accept && !w_loaded) begin
          r_count <= r_count + 5'd1;
        end
        if ((w_accept && w_loaded) || (bus.i_tap_wr && (r_state == S_READ))) begin
          r_err <= 1'b1;
        end
      end
      if (w_start) begin
        r_rd_idx <= '0;
      end else if (w_transfer && !bus.i_clear) begin
        r_rd_idx <= r_rd_idx + 4'd1;
      end
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_flat
    assign bus.o_taps[TW*k +: TW] = r_taps[k];
  end

`ifdef TAP_BANK_CHECKSUM_EN
  logic [19:0] r_checksum;

  always_ff @(posedge clk) begin
    if (i_reset || bus.i_clear) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + 20'(bus.i_tap);
    end
  end

  assign bus.o_checksum = r_checksum;
`else
  assign bus.o_checksum = '0;
`endif

  assign bus.o_rd_valid = (r_state == S_READ);
  assign bus.o_rd_data  = r_taps[w_rd_sel];
  assign bus.o_rd_idx   = r_rd_idx;
  // A clear arriving in DONE suppresses the completion pulse.
  assign bus.o_rd_done  = (r_state == S_DONE) & ~bus.i_clear;
  assign bus.o_count    = r_count;
  assign bus.o_loaded   = w_loaded;
  assign bus.o_err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tap_bank.sv
// tb_tap_bank: directed self-checking bench for tap_bank.
`default_nettype none

module tb_tap_bank;
  localparam int NTAPS = 16;
  localparam int TW    = 16;

  logic clk = 1'b0;
  logic i_reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  tap_bank_if #(.NTAPS(NTAPS), .TW(TW)) bus ();

  tap_bank #(.NTAPS(NTAPS), .TW(TW)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] get_tap(input int k);
    logic [NTAPS*TW-1:0] flat;
    flat = bus.o_taps;
    return flat[TW*k +: TW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic load_seq();
    do_reset();
    for (int i = 1; i <= NTAPS; i++) begin
      bus.i_tap_wr = 1'b1;
      bus.i_tap    = 16'(i);
      tick();
    end
    bus.i_tap_wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.o_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.o_count); end
    n_checks++; if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.o_err); end
    n_checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_rd_done !== 1'b0) begin n_fail++; $display("FAIL reset_rd got valid=%b done=%b exp 0 0", bus.o_rd_valid, bus.o_rd_done); end
    n_checks++; if (bus.o_taps !== '0) begin n_fail++; $display("FAIL reset_taps got %h exp 0", bus.o_taps); end
    n_checks++; if (bus.o_checksum !== 20'd0 || bus.o_rd_idx !== 4'd0) begin n_fail++; $display("FAIL reset_misc got cks=%h idx=%0d exp 0 0", bus.o_checksum, bus.o_rd_idx); end
  endtask

  task automatic test_load();
    logic [19:0] exp_cks;
`ifdef TAP_BANK_CHECKSUM_EN
    exp_cks = 20'd136;
`else
    exp_cks = 20'd0;
`endif
    load_seq();
    n_checks++; if (bus.o_count !== 5'd16) begin n_fail++; $display("FAIL load_count got %0d exp 16", bus.o_count); end
    n_checks++; if (bus.o_loaded !== 1'b1) begin n_fail++; $display("FAIL load_loaded got %b exp 1", bus.o_loaded); end
    n_checks++; if (get_tap(15) !== 16'h0001) begin n_fail++; $display("FAIL load_tap15 got %h exp 0001", get_tap(15)); end
    n_checks++; if (get_tap(0) !== 16'h0010) begin n_fail++; $display("FAIL load_tap0 got %h exp 0010", get_tap(0)); end
    n_checks++; if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL load_err got %b exp 0", bus.o_err); end
    n_checks++; if (bus.o_checksum !== exp_cks) begin n_fail++; $display("FAIL load_checksum got %h exp %h", bus.o_checksum, exp_cks); end
  endtask

  task automatic test_readback();
    bus.i_rd_start = 1'b1;
    bus.i_rd_ready = 1'b1;
    tick();
    bus.i_rd_start = 1'b0;
    for (int i = 0; i < NTAPS; i++) begin
      n_checks++;
      if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== 16'(i + 1) || bus.o_rd_idx !== 4'(i) || bus.o_rd_done !== 1'b0) begin
        n_fail++;
        $display("FAIL rb_beat%0d got v=%b d=%h idx=%0d done=%b exp 1 %h %0d 0", i, bus.o_rd_valid, bus.o_rd_data, bus.o_rd_idx, bus.o_rd_done, 16'(i + 1), i);
      end
      tick();
    end
    n_checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_rd_done !== 1'b1) begin n_fail++; $display("FAIL rb_done got v=%b done=%b exp 0 1", bus.o_rd_valid, bus.o_rd_done); end
    tick();
    n_checks++; if (bus.o_rd_done !== 1'b0 || bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rb_idle got v=%b done=%b exp 0 0", bus.o_rd_valid, bus.o_rd_done); end
    n_checks++; if (bus.o_count !== 5'd16 || get_tap(0) !== 16'h0010) begin n_fail++; $display("FAIL rb_unchanged got cnt=%0d tap0=%h exp 16 0010", bus.o_count, get_tap(0)); end
  endtask

  task automatic test_overflow();
    bus.i_tap_wr = 1'b1;
    bus.i_tap    = 16'hAAAA;
    tick();
    bus.i_tap_wr = 1'b0;
    n_checks++; if (get_tap(0) !== 16'hAAAA || get_tap(15) !== 16'h0002) begin n_fail++; $display("FAIL ovf_taps got tap0=%h tap15=%h exp AAAA 0002", get_tap(0), get_tap(15)); end
    n_checks++; if (bus.o_count !== 5'd16 || bus.o_err !== 1'b1) begin n_fail++; $display("FAIL ovf_status got cnt=%0d err=%b exp 16 1", bus.o_count, bus.o_err); end
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    n_checks++; if (bus.o_count !== 5'd0 || bus.o_err !== 1'b0 || bus.o_loaded !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got cnt=%0d err=%b ld=%b exp 0 0 0", bus.o_count, bus.o_err, bus.o_loaded); end
    n_checks++; if (get_tap(0) !== 16'hAAAA || get_tap(15) !== 16'h0002) begin n_fail++; $display("FAIL ovf_kept got tap0=%h tap15=%h exp AAAA 0002", get_tap(0), get_tap(15)); end
  endtask

  task automatic test_stall();
    load_seq();
    bus.i_rd_start = 1'b1;
    bus.i_rd_ready = 1'b1;
    tick();
    bus.i_rd_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus.i_rd_ready = 1'b0;
    bus.i_tap_wr   = 1'b1;
    bus.i_tap      = 16'hBEEF;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== 16'h0006 || bus.o_rd_idx !== 4'd5) begin
        n_fail++;
        $display("FAIL stall_hold%0d got v=%b d=%h idx=%0d exp 1 0006 5", c, bus.o_rd_valid, bus.o_rd_data, bus.o_rd_idx);
      end
      tick();
    end
    bus.i_tap_wr = 1'b0;
    n_checks++; if (bus.o_err !== 1'b1) begin n_fail++; $display("FAIL stall_err got %b exp 1", bus.o_err); end
    for (int k = 0; k < NTAPS; k++) begin
      n_checks++;
      if (get_tap(k) !== 16'(NTAPS - k)) begin n_fail++; $display("FAIL stall_tap%0d got %h exp %h", k, get_tap(k), 16'(NTAPS - k)); end
    end
    bus.i_rd_ready = 1'b1;
    for (int i = 5; i < NTAPS; i++) tick();
    n_checks++; if (bus.o_rd_done !== 1'b1) begin n_fail++; $display("FAIL stall_done got %b exp 1", bus.o_rd_done); end
    tick();
  endtask

  task automatic test_clear_reset();
    bus.i_clear  = 1'b1;
    bus.i_tap_wr = 1'b1;
    bus.i_tap    = 16'h1234;
    tick();
    bus.i_clear  = 1'b0;
    bus.i_tap_wr = 1'b0;
    n_checks++; if (bus.o_count !== 5'd0 || bus.o_err !== 1'b0 || get_tap(0) !== 16'h0010) begin n_fail++; $display("FAIL clr_wr got cnt=%0d err=%b tap0=%h exp 0 0 0010", bus.o_count, bus.o_err, get_tap(0)); end
    load_seq();
    bus.i_rd_start = 1'b1;
    bus.i_rd_ready = 1'b1;
    tick();
    bus.i_rd_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    n_checks++; if (bus.o_rd_idx !== 4'd7 || bus.o_rd_data !== 16'h0008) begin n_fail++; $display("FAIL rst_pre got idx=%0d d=%h exp 7 0008", bus.o_rd_idx, bus.o_rd_data); end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    n_checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_rd_done !== 1'b0 || bus.o_rd_idx !== 4'd0) begin n_fail++; $display("FAIL rst_rd got v=%b done=%b idx=%0d exp 0 0 0", bus.o_rd_valid, bus.o_rd_done, bus.o_rd_idx); end
    n_checks++; if (bus.o_count !== 5'd0 || bus.o_taps !== '0 || bus.o_err !== 1'b0) begin n_fail++; $display("FAIL rst_state got cnt=%0d err=%b taps=%h exp 0 0 0", bus.o_count, bus.o_err, bus.o_taps); end
    tick();
    n_checks++; if (bus.o_rd_done !== 1'b0 || bus.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after got v=%b done=%b exp 0 0", bus.o_rd_valid, bus.o_rd_done); end
  endtask

  task automatic test_checksum();
    logic [19:0] exp_cks;
`ifdef TAP_BANK_CHECKSUM_EN
    exp_cks = 20'hFFFF0;
`else
    exp_cks = 20'd0;
`endif
    do_reset();
    for (int i = 0; i < NTAPS; i++) begin
      bus.i_tap_wr = 1'b1;
      bus.i_tap    = 16'hFFFF;
      tick();
    end
    bus.i_tap_wr = 1'b0;
    n_checks++; if (bus.o_checksum !== exp_cks) begin n_fail++; $display("FAIL checksum got %h exp %h", bus.o_checksum, exp_cks); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset        = 1'b1;
    bus.i_tap_wr   = 1'b0;
    bus.i_tap      = '0;
    bus.i_clear    = 1'b0;
    bus.i_rd_start = 1'b0;
    bus.i_rd_ready = 1'b0;
    test_reset();
    test_load();
    test_readback();
    test_overflow();
    test_stall();
    test_clear_reset();
    test_checksum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/tap_bank.md
TAP_BANK -- requirements
Module: tap_bank

Interface
REQ-001 Parameter NTAPS, 16, number of taps held.
REQ-002 Parameter TW, 16, tap width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 i_reset  input  1  reset, synchronous, active-high.
REQ-005 i_tap_wr  input  1  tap write strobe, active-high, one tap per asserted cycle.
REQ-006 i_tap  input  TW  tap word, sampled when i_tap_wr=1.
REQ-007 i_clear  input  1  clears load count, error flag and checksum; taps untouched.
REQ-008 i_rd_start  input  1  request serial readback of all taps.
REQ-009 i_rd_ready  input  1  readback consumer ready.
REQ-010 o_rd_valid  output  1  readback word valid.
REQ-011 o_rd_data  output  TW  readback word.
REQ-012 o_rd_idx  output  4  write-order index of o_rd_data.
REQ-013 o_rd_done  output  1  one-cycle pulse after last readback transfer.
REQ-014 o_count  output  5  accepted writes since clear, saturating at NTAPS.
REQ-015 o_loaded  output  1  high when o_count==NTAPS.
REQ-016 o_err  output  1  sticky write-error flag.
REQ-017 o_taps  output  NTAPS*TW  flattened bank; tap[k] at bits [TW*k+TW-1 : TW*k].
REQ-018 o_checksum  output  20  running tap sum (see Configuration).

Function
REQ-019 Accepted write: tap[0] <= i_tap; tap[k] <= tap[k-1] for k=1..NTAPS-1; first of 16 writes ends in tap[15].
REQ-020 Write accepted only when i_tap_wr=1, i_clear=0, FSM not READ.
REQ-021 Accepted write: o_count increments, saturates at NTAPS.
REQ-022 Accepted write while o_loaded=1: bank still shifts; o_err set.
REQ-023 i_tap_wr=1 during READ: write dropped, bank unchanged, o_err set.
REQ-024 o_err cleared only by i_clear or i_reset.
REQ-025 i_clear priority over same-cycle write: write dropped, o_count=0 next cycle, o_err not set.
REQ-026 FSM states IDLE, READ, DONE; reset state IDLE.
REQ-027 IDLE -> READ when i_rd_start=1 and o_loaded=1; o_rd_idx <= 0; i_rd_start ignored otherwise.
REQ-028 READ: o_rd_valid=1; o_rd_data = tap[NTAPS-1-o_rd_idx] (combinational from registered index), i.e. write order.
REQ-029 Transfer = o_rd_valid & i_rd_ready; o_rd_idx increments on each transfer; o_rd_valid, o_rd_data stable while i_rd_ready=0.
REQ-030 Transfer at o_rd_idx==NTAPS-1 -> DONE; DONE: o_rd_valid=0, o_rd_done=1 one cycle, then IDLE.
REQ-031 i_clear during READ or DONE: next cycle IDLE, o_rd_valid=0, no o_rd_done pulse.
REQ-032 o_rd_valid=0 and o_rd_done=0 in IDLE; i_rd_start in READ/DONE ignored.
REQ-033 Readback does not modify taps or o_count.

Reset
REQ-034 i_reset=1 at clock edge: all taps 0, o_count 0, o_err 0, FSM IDLE, o_rd_idx 0, o_rd_valid 0, o_rd_done 0, o_checksum 0.
REQ-035 i_reset priority over all inputs, incl. mid-readback and same-cycle write.

Configuration
REQ-036 Macro TAP_BANK_CHECKSUM_EN defined: o_checksum <= o_checksum + i_tap (unsigned, mod 2^20) per accepted write; zeroed by i_clear/i_reset.
REQ-037 Macro undefined: no checksum register; o_checksum tied to 0; all else identical.

Verification
REQ-038 After reset, write 16 taps 0x0001..0x0010 -> o_count=16, o_loaded=1, tap[15]=0x0001, tap[0]=0x0010, o_err=0.
REQ-039 Loaded bank, i_rd_start=1, i_rd_ready=1 -> 16 valid cycles, data 0x0001..0x0010, idx 0..15, then o_rd_done one cycle.
REQ-040 Readback with i_rd_ready held 0 for 3 cycles at idx 5 -> o_rd_data=0x0006 held stable; i_tap_wr=1 in that window -> bank unchanged, o_err=1.
REQ-041 17th write 0xAAAA when loaded -> tap[0]=0xAAAA, tap[15]=0x0002, o_count=16, o_err=1; i_clear -> o_count=0, o_err=0, taps kept.
REQ-042 i_clear with i_tap_wr same cycle -> write dropped, o_count=0; i_reset at readback idx 7 -> idle, all outputs zero, no o_rd_done.
REQ-043 TAP_BANK_CHECKSUM_EN defined, 16 writes of 0xFFFF -> o_checksum=0xFFFF0; undefined -> o_checksum=0.
